// File: rtl/spi_ram_target.sv
// SPI mode-0 target bridging READ (0x03) / WRITE (0x02) frames onto a byte-wide
// memory port. All SPI pins are resynchronised into clk; nothing runs on spi_clk.
`timescale 1ns/1ps
module spi_ram_target #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_clk,
  input  logic                 spi_select,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 busy
);
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_IGNORE} state_t;

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);

  logic [2:0]           sclk_q, sclk_d;
  logic [2:0]           sel_q, sel_d;
  logic [1:0]           mosi_q, mosi_d;
  logic                 primed_q, primed_d;
  logic                 armed_q, armed_d;
  state_t               state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [ADDR_BITS-1:0] shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 is_read_q, is_read_d;
  logic [7:0]           tx_sr_q, tx_sr_d;
  logic                 miso_q, miso_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;
  logic                 load_pend_q, load_pend_d;
  logic                 inc_pend_q, inc_pend_d;

  logic                 clk_rise, clk_fall, sel_rise, sel_fall;
  logic [ADDR_BITS-1:0] shifted;

  assign clk_rise = sclk_q[1] & ~sclk_q[2];
  assign clk_fall = ~sclk_q[1] & sclk_q[2];
  assign sel_rise = sel_q[1] & ~sel_q[2];
  // A falling select only counts once the pin has been seen high since reset.
  assign sel_fall = armed_q & ~sel_q[1] & sel_q[2];
  assign shifted  = {shift_q[ADDR_BITS-2:0], mosi_q[1]};

  always_comb begin
    sclk_d      = {sclk_q[1:0], spi_clk};
    sel_d       = {sel_q[1:0], spi_select};
    mosi_d      = {mosi_q[0], spi_mosi};
    primed_d    = 1'b1;
    armed_d     = armed_q | (primed_q & sel_q[0]);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    load_pend_d = 1'b0;
    inc_pend_d  = 1'b0;

    if (sel_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 5'd0;
      shift_d   = '0;
      tx_sr_d   = 8'd0;
    end else begin
      // Read data lands one cycle after the strobe; capture it the cycle after that.
      if (load_pend_q && state_q == ST_READ) tx_sr_d = mem_rdata;
      if (inc_pend_q) addr_d = addr_q + 1'b1;
      if (mem_re_q) load_pend_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (sel_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 5'd0;
          end
        end
        ST_CMD: begin
          if (clk_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if (shifted[7:0] == 8'h03) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b1;
              end else if (shifted[7:0] == 8'h02) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b0;
              end else begin
                state_d   = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR: begin
          if (clk_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_d = 5'd0;
              addr_d    = shifted;
              if (is_read_q) begin
                state_d    = ST_READ;
                mem_re_d   = 1'b1;
                mem_addr_d = shifted;
              end else begin
                state_d    = ST_WRITE;
              end
            end
          end
        end
        ST_READ: begin
          if (clk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            // Last bit of the byte is being sampled: prefetch the next address.
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = 5'd0;
              addr_d     = addr_q + 1'b1;
              mem_re_d   = 1'b1;
              mem_addr_d = addr_q + 1'b1;
            end
          end
          if (clk_fall) begin
            miso_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
        ST_WRITE: begin
          if (clk_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d   = 5'd0;
              mem_we_d    = 1'b1;
              mem_wdata_d = shifted[7:0];
              mem_addr_d  = addr_q;
              inc_pend_d  = 1'b1;
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != ST_READ) miso_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= 3'b000;
      sel_q       <= 3'b111;
      mosi_q      <= 2'b00;
      primed_q    <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      tx_sr_q     <= 8'd0;
      miso_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      load_pend_q <= 1'b0;
      inc_pend_q  <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      sel_q       <= sel_d;
      mosi_q      <= mosi_d;
      primed_q    <= primed_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      load_pend_q <= load_pend_d;
      inc_pend_q  <= inc_pend_d;
    end
  end

  assign spi_miso  = miso_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = ~sel_q[1];
endmodule
